// File: rtl/tdm_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between NUM_REQ requesters.
// A tag pipeline follows each grant through the multiplier and steers the product back.

module tdm_mult_resp_lane #(
  parameter int PW  = 1,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tag_vld,
  input  logic [PW-1:0] tag_idx,
  output logic          resp_valid
);
  localparam logic [PW-1:0] LANE_ID = PW'(IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) resp_valid <= 1'b0;
    else        resp_valid <= tag_vld && (tag_idx == LANE_ID);
  end
endmodule

module tdm_mult_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int WIDTH_A      = 8,
  parameter int WIDTH_B      = 8,
  parameter int MULT_LATENCY = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][WIDTH_A-1:0]       req_a,
  input  logic [NUM_REQ-1:0][WIDTH_B-1:0]       req_b,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [WIDTH_A-1:0]                    mult_a,
  output logic [WIDTH_B-1:0]                    mult_b,
  input  logic [WIDTH_A+WIDTH_B-1:0]            mult_p,
  output logic [NUM_REQ-1:0]                    resp_valid,
  output logic [WIDTH_A+WIDTH_B-1:0]            resp_p,
  output logic [$clog2(MULT_LATENCY+2)-1:0]     inflight,
  output logic [15:0]                           issue_count,
  output logic                                  idle
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW = $clog2(MULT_LATENCY+2);
  localparam logic [PW:0]   NREQ = (PW+1)'(NUM_REQ);
  localparam logic [PW-1:0] LAST = PW'(NUM_REQ-1);

  logic [PW-1:0]       ptr;
  logic [PW-1:0]       grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic                hs;
  logic [PW:0]         sum;
  logic [PW-1:0]       cand;
  logic                found;

  logic [MULT_LATENCY:0]         vld_pipe;
  logic [MULT_LATENCY:0][PW-1:0] idx_pipe;

  // First valid requester at or after ptr, wrapping; reset also blocks grants.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum  = {1'b0, ptr} + (PW+1)'(k);
      cand = (sum >= NREQ) ? PW'(sum - NREQ) : PW'(sum);
      if (!found && en && rst_n && req_valid[cand]) begin
        found           = 1'b1;
        grant_idx       = cand;
        grant[cand]     = 1'b1;
      end
    end
  end

  assign req_ready = grant;
  assign hs        = found;
  assign idle      = (inflight == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
      vld_pipe    <= '0;
      idx_pipe    <= '0;
      resp_p      <= '0;
      inflight    <= '0;
      issue_count <= '0;
    end else begin
      if (hs) begin
        ptr         <= (grant_idx == LAST) ? '0 : grant_idx + PW'(1);
        mult_a      <= req_a[grant_idx];
        mult_b      <= req_b[grant_idx];
        issue_count <= issue_count + 16'd1;
      end
      vld_pipe[0] <= hs;
      idx_pipe[0] <= grant_idx;
      for (int k = 1; k <= MULT_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        idx_pipe[k] <= idx_pipe[k-1];
      end
      // Last tag stage lines up with the product currently on mult_p.
      if (vld_pipe[MULT_LATENCY]) resp_p <= mult_p;
      case ({hs, vld_pipe[MULT_LATENCY]})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    tdm_mult_resp_lane #(.PW(PW), .IDX(i)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .tag_vld    (vld_pipe[MULT_LATENCY]),
      .tag_idx    (idx_pipe[MULT_LATENCY]),
      .resp_valid (resp_valid[i])
    );
  end
endmodule

// File: doc/tdm_mult_arbiter.md
# tdm_mult_arbiter

Round-robin arbiter and sequencer that shares one pipelined DSP48 multiplier between `NUM_REQ` requesters in the TDM clock domain. Each cycle it grants at most one requester, registers that operand pair onto the multiplier inputs, and tracks the grant through the fixed multiplier latency with a tag pipeline. It routes each product back to the requester that issued it as a one-cycle response pulse. It replaces the free-running source rotation ahead of the multiplier with demand-driven, fair scheduling.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `WIDTH_A`, default 8: operand A width (unsigned).
- `WIDTH_B`, default 8: operand B width (unsigned).
- `MULT_LATENCY`, default 4: cycles from multiplier input registers to `mult_p` valid (AD/B, M, P pipeline stages), ≥1.
- `clk`  in  1  TDM clock (2x system clock); the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `en`  in  1  grant enable; low blocks new grants, in-flight operations still complete.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_a`  in  NUM_REQ×WIDTH_A  per-requester operand A.
- `req_b`  in  NUM_REQ×WIDTH_B  per-requester operand B.
- `req_ready`  out  NUM_REQ  per-requester grant; one-hot or zero.
- `mult_a`  out  WIDTH_A  registered multiplier A input.
- `mult_b`  out  WIDTH_B  registered multiplier B input.
- `mult_p`  in  WIDTH_A+WIDTH_B  multiplier product.
- `resp_valid`  out  NUM_REQ  one-cycle response pulse, one-hot or zero.
- `resp_p`  out  WIDTH_A+WIDTH_B  registered product for the pulsed requester.
- `inflight`  out  clog2(MULT_LATENCY+2)  operations issued but not yet responded.
- `issue_count`  out  16  total handshakes since reset; wraps at 0xFFFF→0.
- `idle`  out  1  high when `inflight`==0.

## Operation
- Handshake: requester i is accepted in a cycle where `req_valid[i] && req_ready[i]`.
- `req_ready` is combinational from `req_valid`, `en` and the pointer. `req_valid` must not depend on `req_ready`.
- Grant selection: choose the first i with `req_valid[i]`, scanning from `ptr` upward modulo NUM_REQ. If `en`==0 or no request is valid, all ready bits are 0.
- Pointer: `ptr` ← granted index + 1 (mod NUM_REQ) on a handshake; otherwise it holds.
- Fairness: continuously valid requesters are each served once per NUM_REQ grants.
- Issue stage: on a handshake, `mult_a`/`mult_b` load the granted operands and the issue tag {valid=1, idx} enters the tag pipeline. With no handshake, `mult_a`/`mult_b` hold their value and a bubble (valid=0) enters.
- Tag pipeline: MULT_LATENCY+1 stages, aligned so the tag for the operation whose product appears on `mult_p` is at its last stage in that cycle.
- Response: if the last-stage tag is valid, `resp_p` ← `mult_p` and `resp_valid[idx]` pulses for exactly 1 cycle. Otherwise `resp_valid` is 0 and `resp_p` holds.
- There is no response backpressure; requesters must accept the pulse.
- `inflight`: +1 on handshake, −1 on response, net 0 when both occur in the same cycle. Maximum is MULT_LATENCY+1.
- Arithmetic: the product is unsigned and full width WIDTH_A+WIDTH_B, with no truncation.
- Reset (`rst_n` low at a clock edge) clears:
  - `ptr`, `mult_a`, `mult_b`, all tag valid bits, `resp_valid`, `resp_p`, `inflight` and `issue_count` to 0;
  - `req_ready` is 0 while reset is asserted.
- Reset mid-operation drops in-flight operations. Products emerging after reset produce no response because their tags were cleared.

## Timing
- A handshake in cycle c produces:
  - `mult_a`/`mult_b` valid in cycle c+1;
  - `mult_p` valid in cycle c+1+MULT_LATENCY;
  - `resp_valid`/`resp_p` in cycle c+2+MULT_LATENCY.
- Total request-to-response latency is MULT_LATENCY+2 cycles (6 with defaults).
- Throughput is 1 operation per cycle across all requesters.
- `issue_count`, `inflight` and `idle` update on the cycle after the triggering event.
- `en` deasserted in cycle c: no grant in cycle c. Operations granted before c still respond on schedule.

## Test plan
- Single request: reset, then req0 with a=3, b=7 for one cycle → `req_ready[0]`=1 that cycle; `mult_a`=3 and `mult_b`=7 next cycle; `resp_valid[0]` with `resp_p`=21 six cycles after the handshake; `inflight` returns to 0.
- Contention: both requesters held valid for 8 cycles with req0 (a=2, b=k) and req1 (a=5, b=k) → grants alternate 0,1,0,1…; responses alternate in the same order; products are correct; `issue_count`=8.
- Full width: a=0xFF, b=0xFF → `resp_p`=0xFE01.
- Back-to-back: req1 alone valid for 10 cycles → 10 consecutive grants; 10 consecutive `resp_valid[1]` pulses; `inflight` peaks at MULT_LATENCY+1=5.
- `en` gating: drop `en` for 3 cycles mid-stream → no ready during those cycles; earlier results still arrive; grants resume from the unchanged `ptr`.
- Reset mid-flight: issue 3 operations, assert `rst_n`=0 for 1 cycle two cycles later → no `resp_valid` pulses afterward; `inflight`=0; `issue_count`=0; `ptr`=0.
